// File: rtl/memory_bus_target.sv
// memory_bus_target: core memory-bus target serving a block RAM, an MMIO
// timer/IRQ register file and an always-answering unmapped responder.
module memory_bus_target #(
  parameter int                      ADDRESS_SIZE  = 15,
  parameter logic [ADDRESS_SIZE-1:0] RAM_BASE      = 15'h2000,
  parameter int                      RAM_ADDR_BITS = 10,
  parameter int                      WAIT_STATES   = 0,
  parameter logic [ADDRESS_SIZE-1:0] MMIO_BASE     = 15'h7F00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] memAddress,
  input  logic                    memStrobe,
  input  logic                    memWriteEnable,
  input  logic [31:0]             memDataWrite,
  output logic                    memReady,
  output logic [31:0]             memDataRead,
  output logic [1:0]              interruptReq,
  output logic                    busError
);

  localparam int RAM_LSB   = RAM_ADDR_BITS + 2;
  localparam int RAM_WORDS = 2 ** RAM_ADDR_BITS;
  localparam logic [2:0] WAIT_LAST =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        is_ram_q, is_ram_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ram_rd_q;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  status_q, status_d;
  logic [1:0]  enable_q, enable_d;
  logic [1:0]  irq_q, irq_d;
  logic [31:0] mem_q [RAM_WORDS];

  logic                     ram_hit;
  logic                     mmio_hit;
  logic                     accept;
  logic                     mmio_wr;
  logic                     tmr_hit;
  logic [5:0]               mmio_off;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic [31:0]              mmio_rd;
  logic                     addr_unused;

  // Bases are size-aligned, so a prefix match is the whole range check
  assign ram_hit  = memAddress[ADDRESS_SIZE-1:RAM_LSB]
                 == RAM_BASE[ADDRESS_SIZE-1:RAM_LSB];
  assign mmio_hit = memAddress[ADDRESS_SIZE-1:8]
                 == MMIO_BASE[ADDRESS_SIZE-1:8];
  assign ram_idx  = memAddress[RAM_LSB-1:2];
  assign mmio_off = memAddress[7:2];
  assign accept   = (state_q == S_IDLE) && memStrobe && !reset;
  assign mmio_wr  = accept && mmio_hit && memWriteEnable;
  assign tmr_hit  = (count_q + 32'd1) == compare_q;
  assign addr_unused = ^memAddress[1:0];

  always_comb begin
    mmio_rd = '0;
    case (mmio_off)
      6'd0:    mmio_rd = count_q;
      6'd1:    mmio_rd = compare_q;
      6'd2:    mmio_rd = {30'd0, status_q};
      6'd3:    mmio_rd = {30'd0, enable_q};
      default: mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 3'd1;
        if (wcnt_q == WAIT_LAST)
          state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    memReady    = 1'b0;
    busError    = 1'b0;
    memDataRead = '0;
    if (state_q == S_RESP) begin
      memReady    = 1'b1;
      busError    = err_q;
      memDataRead = is_ram_q ? ram_rd_q : rdata_q;
    end
  end

  assign interruptReq = irq_q;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    enable_d  = enable_q;
    status_d  = status_q;
    irq_d     = status_q & enable_q;
    rdata_d   = rdata_q;
    is_ram_d  = is_ram_q;
    err_d     = err_q;
    if (accept) begin
      rdata_d  = (mmio_hit && !memWriteEnable) ? mmio_rd : '0;
      is_ram_d = ram_hit && !memWriteEnable;
      err_d    = !(ram_hit || mmio_hit);
    end
    if (mmio_wr && mmio_off == 6'd1)
      compare_d = memDataWrite;
    if (mmio_wr && mmio_off == 6'd3)
      enable_d = memDataWrite[1:0];
    if (mmio_wr && mmio_off == 6'd2) begin
      status_d[1] = memDataWrite[1];
      if (memDataWrite[0])
        status_d[0] = 1'b0;
    end
    // A compare match beats a same-edge clear
    if (tmr_hit)
      status_d[0] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      enable_q  <= '0;
      status_q  <= '0;
      irq_q     <= '0;
      rdata_q   <= '0;
      is_ram_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      enable_q  <= enable_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      is_ram_q  <= is_ram_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept && ram_hit && memWriteEnable)
      mem_q[ram_idx] <= memDataWrite;
    if (accept && ram_hit && !memWriteEnable)
      ram_rd_q <= mem_q[ram_idx];
  end

endmodule

// File: doc/memory_bus_target.md
Name: memory_bus_target

Overview:
- Bus target that sits directly downstream of the RISC-V core's memory bus and serves every core access.
- Decodes the byte address and routes each access to one of three places: an on-chip block RAM, a small MMIO register file with a timer, or an unmapped-access responder.
- Generates the core's two interrupt request lines from the timer and a software-interrupt bit.

Parameters:
- ADDRESS_SIZE, 15, byte address width of the bus.
- RAM_BASE, 15'h2000, RAM base byte address; must be aligned to the RAM size.
- RAM_ADDR_BITS, 10, RAM depth in 32-bit words (log2).
- WAIT_STATES, 0, extra cycles inserted before memReady; range 0..7.
- MMIO_BASE, 15'h7F00, base byte address of the 256-byte MMIO window.

Ports:
- clock, in, 1, system clock; all logic is on the rising edge.
- reset, in, 1, synchronous, active-high.
- memAddress, in, ADDRESS_SIZE, byte address; bits [1:0] are ignored.
- memStrobe, in, 1, request; held by the core until memReady is seen.
- memWriteEnable, in, 1, 1 = write, 0 = read.
- memDataWrite, in, 32, write data.
- memReady, out, 1, one-cycle completion pulse.
- memDataRead, out, 32, read data, valid while memReady = 1.
- interruptReq, out, 2, [0] = timer interrupt, [1] = software interrupt.
- busError, out, 1, one-cycle pulse on the memReady cycle of an unmapped access.

Behaviour:
- Reset values: memReady = 0, memDataRead = 0, busError = 0, interruptReq = 0, FSM in IDLE, timer count = 0, compare = 32'hFFFFFFFF, status = 0, enable = 0.
- Reset does not clear RAM contents.
- FSM states: IDLE, WAIT, RESP.
- IDLE: at a rising edge with memStrobe = 1 the request is accepted, and memAddress, memWriteEnable and the region decode are latched.
  - Next state is WAIT if WAIT_STATES > 0, otherwise RESP.
- WAIT: counts WAIT_STATES cycles, then goes to RESP.
- RESP: memReady = 1 for exactly one cycle, then returns to IDLE.
  - memStrobe sampled in RESP is ignored; the core drops it after seeing memReady.
- Latency: memReady is high in cycle N+1+WAIT_STATES, where N is the accept edge. Latency is identical for every region and for reads and writes.
- RAM region (RAM_BASE ≤ addr < RAM_BASE + 4×2^RAM_ADDR_BITS):
  - Word index = addr[RAM_ADDR_BITS+1:2].
  - A write is committed at the accept edge.
  - A read is issued at the accept edge; the synchronous BRAM output is captured into a holding register and driven during RESP.
  - A read of the same address after a write returns the new data.
- MMIO registers (offset from MMIO_BASE):
  - 0x00 TIMER_COUNT: read-only; 32-bit free-running counter, +1 every clock, wraps 32'hFFFFFFFF→0. Writes are ignored.
  - 0x04 TIMER_COMPARE: read/write.
  - 0x08 IRQ_STATUS: bit0 = timer pending, write 1 to clear; bit1 = software pending, written directly.
  - 0x0C IRQ_ENABLE: bits [1:0], read/write.
  - Other offsets in the window read 0 and ignore writes; they are not errors.
  - MMIO reads return the value at the accept edge. MMIO writes are committed at the accept edge.
- Timer pending: bit0 is set at the edge where the count transitions to a value equal to TIMER_COMPARE.
  - If a set and a write-1-to-clear hit the same edge, the set wins.
- interruptReq = IRQ_STATUS[1:0] & IRQ_ENABLE[1:0], registered, so it follows the registers by one cycle.
- Unmapped region (neither RAM nor MMIO):
  - The access completes normally with the same latency, so the bus never hangs.
  - Reads return 0 and writes are dropped.
  - busError pulses together with memReady.
- Reset mid-transaction:
  - The FSM goes to IDLE at the reset edge and memReady is 0 in the next cycle.
  - The pending response is dropped.
  - A RAM write already committed at its accept edge persists.
- Back-to-back accesses: the earliest next accept is the edge after RESP, so the minimum access period is 2 + WAIT_STATES cycles.

Test Plan:
- Reset → memReady = 0, interruptReq = 2'b00, busError = 0. Read MMIO 0x7F04 → 32'hFFFFFFFF.
- WAIT_STATES = 0: write 32'hDEADBEEF to 0x2000 with strobe accepted at N → memReady only in cycle N+1. Read 0x2000 → memDataRead = 32'hDEADBEEF at N'+1. Read 0x2FFC (last word) and 0x2000 hold independent values.
- WAIT_STATES = 3: read 0x2004 accepted at N → memReady low in N+1..N+3, high in N+4 for one cycle only.
- Read 0x1000 (unmapped) → memDataRead = 0 and busError = 1, in the memReady cycle only. Write to 0x1000 → no RAM or MMIO change.
- Write COMPARE = 20, ENABLE = 2'b01 → STATUS[0] sets when the count reaches 20 and interruptReq[0] = 1 one cycle later. Write 1 to STATUS[0] → interruptReq[0] clears. A W1C on the same edge the count hits compare → pending stays 1.
- Assert reset in the WAIT state of a read → no memReady pulse. After reset deasserts, a fresh read of 0x2000 returns data written before the reset.
